// File: rtl/pwr_cntr_pkg.sv
// Shared types and constants for the transition-counter dump logic.
package pwr_cntr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPT,
    SEND,
    CLR,
    NEXT,
    DONE
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int DIR_W_DEF  = 2;

  localparam logic LE_READ  = 1'b1;
  localparam logic LE_WRITE = 1'b0;

endpackage

// File: rtl/pwr_cntr_dump.sv
// Walks the transition-counter memory, streams every count over valid/ready,
// optionally clears each counter after reading it, and accumulates the grand total.
module pwr_cntr_dump
  import pwr_cntr_pkg::*;
#(
  parameter int NUM_CNTR = 3,
  parameter int DIR_W    = DIR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SETTLE   = 1
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    start,
  input  logic                    clr_en,
  output logic                    busy,
  output logic                    done,
  output logic [DIR_W-1:0]        dir,
  output logic                    le,
  input  logic [DATA_W-1:0]       dato_i,
  output logic [DATA_W-1:0]       dato_o,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIR_W-1:0]        out_idx,
  output logic [DATA_W-1:0]       out_data,
  output logic [DATA_W+DIR_W-1:0] total
);

  localparam int ACC_W = DATA_W + DIR_W;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [DIR_W-1:0] LAST_IDX    = DIR_W'(NUM_CNTR - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  state_t            state;
  logic [DIR_W-1:0]  idx;
  logic [SET_W-1:0]  settle_cnt;
  logic              clr_lat;

  // Clearing only ever writes zero; the write strobe is le.
  assign dato_o = '0;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      dir        <= '0;
      le         <= LE_READ;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      total      <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      clr_lat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            clr_lat    <= clr_en;
            idx        <= '0;
            dir        <= '0;
            total      <= '0;
            busy       <= 1'b1;
            settle_cnt <= '0;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CAPT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CAPT: begin
          out_data  <= dato_i;
          out_idx   <= idx;
          total     <= total + ACC_W'(dato_i);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (clr_lat) begin
              le    <= LE_WRITE;
              state <= CLR;
            end else begin
              state <= NEXT;
            end
          end
        end
        CLR: begin
          le    <= LE_READ;
          state <= NEXT;
        end
        // Compare before incrementing so idx never wraps at 2^DIR_W counters.
        NEXT: begin
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx        <= idx + 1'b1;
            dir        <= idx + 1'b1;
            settle_cnt <= '0;
            state      <= ADDR;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwr_cntr_dump.md
# pwr_cntr_dump

Synchronous reader for the transition-counter memory: on a start pulse it walks counter addresses 0..NUM_CNTR-1 over the memory's `dir`/`LE`/`dato` port, captures each 32-bit count, and streams it out on a valid/ready interface. Optionally, it clears each counter after reading it. It also accumulates the grand total of all counters. It replaces bench-driven readout loops, so a power-estimation run can be dumped and re-armed by hardware.

## Interface
- NUM_CNTR, 3, number of counters to dump (addresses 0..NUM_CNTR-1); 1 ≤ NUM_CNTR ≤ 2^DIR_W
- DIR_W, 2, width of memory address `dir`
- DATA_W, 32, counter width
- SETTLE, 1, cycles `dir` is held with `le`=1 before `dato_i` is sampled; ≥1
- clk  input  1  single clock; all logic on rising edge
- reset_L  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin a dump
- clr_en  input  1  clear-after-read enable, sampled with `start`
- busy  output  1  high from accepted start until `done`
- done  output  1  one-cycle pulse after the last counter is handled
- dir  output  DIR_W  memory address
- le  output  1  1 = read (memory drives data), 0 = write
- dato_i  input  DATA_W  memory read data
- dato_o  output  DATA_W  memory write data; always 0 (used only for clearing)
- out_valid  output  1  count available
- out_ready  input  1  consumer accepts count
- out_idx  output  DIR_W  address of presented count
- out_data  output  DATA_W  presented count
- total  output  DATA_W+DIR_W  sum of all counts from the last dump

## Operation
- Reset values: busy=0, done=0, dir=0, le=1, dato_o=0, out_valid=0, out_idx=0, out_data=0, total=0, FSM=IDLE.
- `le` is 1 in every state except CLR. The memory is never written outside CLR, including during reset.
- States:
  - IDLE: on `start`, latch `clr_en`, set idx=0, total=0, busy=1, and go to ADDR. With no `start`, stay in IDLE.
  - ADDR: dir=idx, le=1. Hold SETTLE cycles, then go to CAPT.
  - CAPT: out_data<=dato_i, out_idx<=idx, total<=total+dato_i (zero-extended), then go to SEND.
  - SEND: out_valid=1. out_data and out_idx are stable until `out_ready` is high. On that handshake cycle, clear out_valid and go to CLR if the latched clr_en=1, otherwise go to NEXT.
  - CLR: dir=idx, le=0, dato_o=0 for exactly one cycle, then go to NEXT.
  - NEXT: if idx==NUM_CNTR-1, go to DONE. Otherwise idx<=idx+1 and go to ADDR.
  - DONE: done=1 for one cycle, busy<=0, then go to IDLE.
- `total` holds its value after DONE until the next accepted `start` zeroes it. DATA_W+DIR_W bits cannot overflow for legal NUM_CNTR.
- `start` while busy is ignored, with no effect on state or on the latched clr_en.
- `start` coinciding with the DONE cycle is ignored. It is accepted in IDLE on the following cycle.
- idx never wraps. The NEXT comparison stops the dump at NUM_CNTR-1, even when NUM_CNTR = 2^DIR_W.
- Reset in any state returns to IDLE with reset values on the next edge. A CLR in progress is aborted, and `le` returns to 1 at that edge.

## Timing
- Latency from the start cycle to the first out_valid is SETTLE+2 cycles.
- Per counter with out_ready held high: SETTLE+3 cycles (ADDR×SETTLE, CAPT, SEND, NEXT), plus 1 cycle if clr_en.
- The DONE pulse comes 1 cycle after the final NEXT. busy falls in the same edge at which done falls.
- The `dato_i` sample point is the CAPT edge, SETTLE+1 cycles after `dir` changes. This is the memory's combinational read path.
- out_ready is sampled only in SEND. Backpressure stalls the FSM indefinitely with outputs held.

## Structure
- Shared package `pwr_cntr_pkg`:
  - state enum (IDLE, ADDR, CAPT, SEND, CLR, NEXT, DONE)
  - default DATA_W and DIR_W constants
  - LE_READ=1 and LE_WRITE=0 constants
- Single module; no sub-module warranted. SETTLE counter, idx counter and accumulator are inline registers.

## Test plan
- Memory preloaded {5, 0x1234, 0xFFFFFFFF}, clr_en=0, out_ready=1 → three beats (idx 0,1,2) with those values, 4 cycles apart; total=0x1_0000_1238; done after last; memory unchanged.
- Same preload, clr_en=1 → same three beats; exactly one le=0 cycle per address, at dir 0,1,2 in order; memory reads {0,0,0} afterwards.
- out_ready low for 10 cycles on idx=1 → out_valid and out_data=0x1234 held all 10 cycles; no le=0 pulse and no dir change until the handshake.
- `start` pulsed in each of ADDR, SEND and DONE states → ignored; exactly one dump of 3 beats; clr_en changed mid-dump has no effect.
- reset_L low during CLR of idx=1 → next edge le=1, busy=0, out_valid=0, total=0; counter 2 never cleared.
- NUM_CNTR=4, DIR_W=2, all counters 0xFFFFFFFF → 4 beats, idx 3 last, total=0x3_FFFF_FFFC, no idx wrap.
